// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants and types for the 12-bit SPI loopback.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DATA_W       = 12;
    localparam int CLK_DIV_HALF = 10;
    localparam int CNT_W        = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } master_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SCLK divider and LSB-first transmit FSM advancing on SCLK rises.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_newd,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_mosi
);

    localparam logic [3:0]       c_DIV_LAST = 4'(CLK_DIV_HALF - 1);
    localparam logic [CNT_W-1:0] c_BITS     = CNT_W'(DATA_W);

    logic [3:0]        r_div;
    logic              r_sclk;
    logic              w_rise;

    master_state_t     r_state, w_state_nxt;
    logic [DATA_W-1:0] r_data,  w_data_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_cs,    w_cs_nxt;
    logic              r_mosi,  w_mosi_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 4'd1;
        end
    end

    // The edge on which sclk is about to go high
    assign w_rise = (r_div == c_DIV_LAST) && !r_sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cs    <= w_cs_nxt;
            r_mosi  <= w_mosi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_cs_nxt    = r_cs;
        w_mosi_nxt  = r_mosi;
        if (w_rise) begin
            case (r_state)
                IDLE: begin
                    w_cs_nxt   = 1'b1;
                    w_mosi_nxt = 1'b0;
                    if (i_newd) begin
                        w_data_nxt  = i_din;
                        w_cs_nxt    = 1'b0;
                        w_mosi_nxt  = i_din[0];
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (r_cnt < c_BITS) begin
                        w_mosi_nxt = r_data[r_cnt];
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end else if (i_newd) begin
                        // Chain straight into the next frame with cs held low
                        w_data_nxt = i_din;
                        w_mosi_nxt = i_din[0];
                        w_cnt_nxt  = CNT_W'(1);
                    end else begin
                        w_cs_nxt    = 1'b1;
                        w_mosi_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_sclk = r_sclk;
    assign o_cs   = r_cs;
    assign o_mosi = r_mosi;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Samples mosi on sclk falls while cs is low and assembles words.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              i_cs,
    input  logic              i_mosi,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_done
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    logic              r_sclk_q;
    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dout;
    logic              w_fall;
    logic              w_last;
    logic [DATA_W-1:0] w_word;

    // Fall is seen in the cycle right after sclk drops, while mosi is mid-bit
    assign w_fall = r_sclk_q && !sclk && !i_cs && !rst;
    assign w_last = w_fall && (r_cnt == c_LAST);
    assign w_word = {i_mosi, r_sr[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_q <= 1'b0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
        end else begin
            r_sclk_q <= sclk;
            if (i_cs) begin
                r_cnt <= '0;
            end else if (w_fall) begin
                r_sr <= w_word;
                if (w_last) begin
                    r_cnt  <= '0;
                    r_dout <= w_word;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Completed word is forwarded in the done cycle, then held in r_dout
    assign o_done = w_last;
    assign o_dout = w_last ? w_word : r_dout;

endmodule
`default_nettype wire

// File: rtl/spi_master_and_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_and_slave
// Description : 12-bit SPI loopback: master serialises din, slave rebuilds dout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_and_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done
);

    logic w_cs;
    logic w_sclk;
    logic w_mosi;

    spi_master m1 (
        .clk    (clk),
        .rst    (rst),
        .i_newd (newd),
        .i_din  (din),
        .o_sclk (w_sclk),
        .o_cs   (w_cs),
        .o_mosi (w_mosi)
    );

    spi_slave s1 (
        .clk    (clk),
        .rst    (rst),
        .sclk   (w_sclk),
        .i_cs   (w_cs),
        .i_mosi (w_mosi),
        .o_dout (dout),
        .o_done (done)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_master_and_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_and_slave
// Description : Randomised self-checking bench for the SPI loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_and_slave;

    localparam int c_BIT_T   = 20;
    localparam int c_LATENCY = 11 * c_BIT_T + c_BIT_T / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        newd;
    logic [11:0] din;
    logic [11:0] dout;
    logic        done;
    logic        cs_o, sclk_o, mosi_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master_and_slave dut (
        .clk  (clk),
        .rst  (rst),
        .newd (newd),
        .din  (din),
        .dout (dout),
        .done (done)
    );

    assign cs_o   = dut.w_cs;
    assign sclk_o = dut.w_sclk;
    assign mosi_o = dut.w_mosi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds newd until an sclk rise is seen; reports whether cs went high while waiting
    task automatic start_frame(input logic [11:0] w, input int gap, output bit cs_rose);
        bit   ok;
        logic prev;
        repeat (gap) @(negedge clk);
        din     = w;
        newd    = 1'b1;
        cs_rose = 1'b0;
        ok      = 1'b0;
        prev    = sclk_o;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!prev && sclk_o) begin
                ok = 1'b1;
                break;
            end
            if (cs_o) cs_rose = 1'b1;
            prev = sclk_o;
        end
        newd = 1'b0;
        din  = 12'($urandom);
        exp_q.push_back(w);
        if (!ok) chk("rise_timeout", 0, 1);
    endtask

    // Called on the negedge just after the accepting rise tick
    task automatic finish_frame();
        logic [11:0] w;
        bit          seen;
        bit          cs_hi;
        int          bi;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
            return;
        end
        w     = exp_q.pop_front();
        seen  = 1'b0;
        cs_hi = 1'b0;
        bi    = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (cs_o) cs_hi = 1'b1;
            if ((k % c_BIT_T) == c_BIT_T / 2 && bi < 12) begin
                chk($sformatf("mosi_bit%0d", bi), 32'(mosi_o), 32'(w[bi]));
                bi++;
            end
            if (done) begin
                chk("latency", k, c_LATENCY);
                chk("dout", 32'(dout), 32'(w));
                seen = 1'b1;
                break;
            end
        end
        chk("cs_low_in_frame", 32'(cs_hi), 0);
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("done_single", 32'(done), 0);
            chk("dout_hold", 32'(dout), 32'(w));
        end
    endtask

    initial begin
        bit          rose;
        bit          saw_done;
        int          first_rise;
        logic [11:0] rw;

        rst  = 1'b1;
        newd = 1'b0;
        din  = '0;
        repeat (5) @(negedge clk);
        chk("rst_cs",   32'(cs_o),   1);
        chk("rst_sclk", 32'(sclk_o), 0);
        chk("rst_mosi", 32'(mosi_o), 0);
        chk("rst_dout", 32'(dout),   0);
        chk("rst_done", 32'(done),   0);
        rst = 1'b0;

        first_rise = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sclk_o) begin
                first_rise = k;
                break;
            end
        end
        chk("first_rise", first_rise, 10);

        start_frame(12'hA5C, 0, rose);
        finish_frame();

        start_frame(12'h000, 25, rose);
        finish_frame();
        start_frame(12'hFFF, 25, rose);
        finish_frame();
        start_frame(12'h801, 25, rose);
        finish_frame();

        start_frame(12'h123, 0, rose);
        chk("b2b_cs_gap", 32'(rose), 0);
        finish_frame();

        for (int i = 0; i < 10; i++) begin
            rw = 12'($urandom);
            start_frame(rw, int'($urandom_range(0, 1)) * 25, rose);
            finish_frame();
        end

        // Abort a frame during bit 6
        start_frame(12'h5A5, 25, rose);
        saw_done = 1'b0;
        repeat (6 * c_BIT_T + 5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_cs",   32'(cs_o), 1);
        chk("midrst_dout", 32'(dout), 0);
        repeat (300) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 32'(saw_done), 0);
        chk("midrst_dout_idle", 32'(dout), 0);

        start_frame(12'h3C3, 0, rose);
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_and_slave.md
# spi_master_and_slave

Self-contained 12-bit SPI loopback: an SPI master serialises a parallel word onto CS/SCLK/MOSI and an SPI slave inside the same block deserialises it back to a parallel word. It is used as a bring-up and verification vehicle for the SPI link. All logic runs on one system clock, and SCLK is a derived, registered signal.

## Interface
- No parameters. Constants are listed under Structure.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `newd` in 1: transfer request. Sampled only on an SCLK-rise tick, so the requester holds it until SCLK rises.
- `din` in 12: word to transmit. Latched together with `newd`.
- `dout` out 12: last word received by the slave. Held between frames.
- `done` out 1: one-`clk` pulse when `dout` is updated.

## Operation
- SCLK generator (in the master):
  - A 0..9 counter toggles `sclk` when it reaches 9, giving an SCLK period of 20 `clk` cycles.
  - A "rise tick" is the `clk` edge on which `sclk` goes 0→1; a "fall tick" is the edge on which it goes 1→0.
- Master FSM, advancing on rise ticks only:
  - IDLE: `cs`=1, `mosi`=0. If `newd`=1: latch `din`, set `cs`=0, `mosi`=din[0], bit count=1, go to SEND.
  - SEND: while bit count < 12, `mosi`=data[count] and count increments (LSB first).
  - SEND, at the rise tick after bit 11: if `newd`=1, start the next frame immediately (`cs` stays 0, `mosi`=new din[0]). Otherwise set `cs`=1, `mosi`=0 and return to IDLE.
- Slave, operating in the `clk` domain:
  - Takes `sclk`, `cs`, `mosi` as inputs.
  - On each fall tick with `cs`=0: shift register ← {mosi, sr[11:1]} and bit count increments.
  - On the 12th sample: `dout` ← assembled word, `done`=1 for exactly one `clk`, bit count ← 0.
  - `cs`=1 clears the bit count.
- Reset values:
  - `sclk`=0, divider=0, `cs`=1, `mosi`=0, master in IDLE.
  - Slave count=0, `dout`=0, `done`=0.
- Reset mid-frame: abort the frame immediately. No `done` pulse is produced and `dout` returns to 0.
- `newd` asserted while SEND is mid-frame is ignored, except at the final rise tick of a frame.
- `din` changes after latching have no effect on the current frame.

## Timing
- Bit time is 20 `clk`. MOSI changes on rise ticks and is sampled on fall ticks (mid-bit).
- Latency from the accepting rise tick to `done`: 11 bit times + 10 `clk` = 230 `clk`.
- `done` is a single-cycle pulse; `dout` is valid from that cycle on.
- Between frames, `cs` is high for at least one bit time if `newd` is low at the final rise tick. Frames run back-to-back otherwise.
- First rise tick after reset release: 10 `clk` later.

## Structure
- Shared package `spi_pkg` holds:
  - `DATA_W` = 12.
  - `CLK_DIV_HALF` = 10.
  - Master state enum {IDLE, SEND}.
- Natural sub-modules: `spi_master` (SCLK generator + TX FSM) and `spi_slave` (RX shifter). The slave instance is named `s1` and exposes port `sclk`; the top only wires `cs`, `sclk` and `mosi` between them.

## Test plan
- Reset: hold `rst` 5 cycles, then check `cs`=1, `sclk`=0, `mosi`=0, `dout`=0, `done`=0. First `sclk` rise occurs 10 `clk` after release.
- Single frame: `din`=12'hA5C, `newd` held to the first SCLK rise. Check MOSI bits are LSB first (0,0,1,1,1,0,1,0,0,1,0,1), `done` pulses once after 230 `clk`, and `dout`=12'hA5C.
- Boundary words: 12'h000 then 12'hFFF, then 12'h801. Check `dout` matches each word and `done` pulses exactly once per frame.
- Back-to-back: after `done`, assert `newd` with `din`=12'h123 before the next SCLK rise. Check `cs` stays low, the frame starts with no gap, and `dout`=12'h123.
- Ten random words, each issued with `newd` held to an SCLK rise and followed by a wait for `done`. Check all ten `dout` values match.
- Mid-frame reset: assert `rst` at bit 6 of a frame. Check `done` never pulses, `cs`=1, `dout`=0, and the next frame (12'h3C3) completes correctly.
